ad_ip_jesd204_tpl_adc_pnmon: RTL and testbench



---
 rtl/ad_ip_jesd204_tpl_adc_pnmon.sv | 149 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_pnmon.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
// rtl/ad_ip_jesd204_tpl_adc_pnmon.sv - per-channel JESD204 ADC PN sequence monitor
module ad_ip_jesd204_tpl_adc_pnmon #(
   parameter int DATA_PATH_WIDTH      = 2,
   parameter int CONVERTER_RESOLUTION = 16,
   parameter int OOS_THRESHOLD        = 16
) (
   input  logic                                            link_clk,
   input  logic                                            adc_rst,
   input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] data,
   input  logic [3:0]                                      pn_seq_sel,
   output logic                                            pn_err,
   output logic                                            pn_oos
);

   localparam int W  = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
   localparam int HW = 31;
   localparam int CW = $clog2(OOS_THRESHOLD) + 1;

   typedef enum logic {OOS, IN_SYNC} state_t;

   logic [HW-1:0]   history;
   logic [HW-1:0]   history_next;
   logic [HW-1:0]   hist_q;
   logic [W-1:0]    data_q;
   logic [3:0]      sel_q;
   logic [3:0]      sel_d;
   logic            mismatch_q;
   logic            chg_q;
   logic            idle_q;
   logic [HW+W-1:0] in_ext;
   logic [HW+W-1:0] ev_ext;
   logic            e9, e23, e15, e31;
   logic            word_err;

   state_t          state, state_n;
   logic [CW-1:0]   count, count_n;
   logic            err_n;
   logic            oos_n;

   // Time position k of the word: sample 0 first, MSB first within a sample.
   function automatic int stream_idx(input int k);
      return (k / CONVERTER_RESOLUTION) * CONVERTER_RESOLUTION
             + CONVERTER_RESOLUTION - 1 - (k % CONVERTER_RESOLUTION);
   endfunction

   // ext vectors hold the stream oldest bit at index 0, newest at the top.
   always_comb begin
      in_ext = '0;
      ev_ext = '0;
      for (int i = 0; i < HW; i++) begin
         in_ext[i] = history[i];
         ev_ext[i] = hist_q[i];
      end
      for (int k = 0; k < W; k++) begin
         in_ext[HW+k] = data[stream_idx(k)];
         ev_ext[HW+k] = data_q[stream_idx(k)];
      end
      history_next = in_ext[W +: HW];
   end

   always_comb begin
      e9  = 1'b0;
      e23 = 1'b0;
      e15 = 1'b0;
      e31 = 1'b0;
      for (int k = 0; k < W; k++) begin
         e9  = e9  | (ev_ext[HW+k] ^ ev_ext[HW+k-9]  ^ ev_ext[HW+k-5]);
         e23 = e23 | (ev_ext[HW+k] ^ ev_ext[HW+k-23] ^ ev_ext[HW+k-18]);
         e15 = e15 | (ev_ext[HW+k] ^ ev_ext[HW+k-15] ^ ev_ext[HW+k-14]);
         e31 = e31 | (ev_ext[HW+k] ^ ev_ext[HW+k-31] ^ ev_ext[HW+k-28]);
      end
      case (sel_q[1:0])
         2'd0:    word_err = e9;
         2'd1:    word_err = e23;
         2'd2:    word_err = e15;
         default: word_err = e31;
      endcase
   end

   always_ff @(posedge link_clk or posedge adc_rst) begin
      if (adc_rst) begin
         data_q     <= '0;
         hist_q     <= '0;
         history    <= '0;
         sel_q      <= '0;
         sel_d      <= '0;
         mismatch_q <= 1'b0;
         chg_q      <= 1'b0;
         idle_q     <= 1'b0;
      end else begin
         data_q     <= data;
         hist_q     <= history;
         history    <= history_next;
         sel_q      <= pn_seq_sel;
         sel_d      <= sel_q;
         // All-zero is the lock-up state of every recurrence, so never a match.
         mismatch_q <= word_err | (data_q == '0);
         chg_q      <= (sel_q != sel_d);
         idle_q     <= (sel_q[3:2] != 2'b00);
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      err_n   = 1'b0;
      if (idle_q || chg_q) begin
         state_n = OOS;
         count_n = '0;
      end else if (state == OOS) begin
         if (mismatch_q) begin
            count_n = '0;
         end else if (count == CW'(OOS_THRESHOLD - 1)) begin
            state_n = IN_SYNC;
            count_n = '0;
         end else begin
            count_n = count + CW'(1);
         end
      end else begin
         if (!mismatch_q) begin
            count_n = '0;
         end else begin
            err_n = 1'b1;
            if (count == CW'(OOS_THRESHOLD - 1)) begin
               state_n = OOS;
               count_n = '0;
            end else begin
               count_n = count + CW'(1);
            end
         end
      end
      oos_n = (state_n == OOS);
   end

   always_ff @(posedge link_clk or posedge adc_rst) begin
      if (adc_rst) begin
         state  <= OOS;
         count  <= '0;
         pn_err <= 1'b0;
         pn_oos <= 1'b1;
      end else begin
         state  <= state_n;
         count  <= count_n;
         pn_err <= err_n;
         pn_oos <= oos_n;
      end
   end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pnmon.sv
// tb/tb_ad_ip_jesd204_tpl_adc_pnmon.sv - scoreboard bench for the PN sequence monitor
module tb_ad_ip_jesd204_tpl_adc_pnmon;

   localparam int DPW = 2;
   localparam int CR  = 16;
   localparam int W   = DPW * CR;
   localparam int TH  = 16;

   logic         link_clk = 1'b0;
   logic         adc_rst;
   logic [W-1:0] data;
   logic [3:0]   pn_seq_sel;
   logic         pn_err;
   logic         pn_oos;

   always #5 link_clk = ~link_clk;

   ad_ip_jesd204_tpl_adc_pnmon #(
      .DATA_PATH_WIDTH      (DPW),
      .CONVERTER_RESOLUTION (CR),
      .OOS_THRESHOLD        (TH)
   ) dut (
      .link_clk   (link_clk),
      .adc_rst    (adc_rst),
      .data       (data),
      .pn_seq_sel (pn_seq_sel),
      .pn_err     (pn_err),
      .pn_oos     (pn_oos)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [30:0] g_hist;
   logic [30:0] m_hist;
   logic        m_sync;
   int          m_cnt;
   logic [3:0]  m_sel_prev;
   logic [1:0]  exp_q[$];
   int          call_n;
   int          lock_call;
   int          err_seen;
   logic        seen_oos;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic taps(input logic [3:0] sel, output int d1, output int d2);
      case (sel)
         4'h0:    begin d1 = 9;  d2 = 5;  end
         4'h1:    begin d1 = 23; d2 = 18; end
         4'h2:    begin d1 = 15; d2 = 14; end
         4'h3:    begin d1 = 31; d2 = 28; end
         default: begin d1 = 0;  d2 = 0;  end
      endcase
   endtask

   function automatic int bit_pos(input int k);
      return (k / CR) * CR + CR - 1 - (k % CR);
   endfunction

   // Transmitter: bit-serial recurrence on its own history (newest bit at [0]).
   task automatic gen_word(input logic [3:0] sel, output logic [W-1:0] w);
      int d1, d2;
      logic b;
      taps(sel, d1, d2);
      w = '0;
      for (int k = 0; k < W; k++) begin
         if (d1 == 0) b = ($urandom_range(0, 1) != 0);
         else         b = g_hist[d1-1] ^ g_hist[d2-1];
         g_hist = {g_hist[29:0], b};
         w[bit_pos(k)] = b;
      end
   endtask

   task automatic model_word(input logic [W-1:0] w, input logic [3:0] sel);
      int d1, d2;
      logic mm, b, err;
      taps(sel, d1, d2);
      mm = (w == '0);
      for (int k = 0; k < W; k++) begin
         b = w[bit_pos(k)];
         if (d1 != 0 && (b ^ m_hist[d1-1] ^ m_hist[d2-1])) mm = 1'b1;
         m_hist = {m_hist[29:0], b};
      end
      err = 1'b0;
      if (d1 == 0 || sel != m_sel_prev) begin
         m_sync = 1'b0;
         m_cnt  = 0;
      end else if (!m_sync) begin
         if (mm) m_cnt = 0;
         else if (m_cnt == TH - 1) begin m_sync = 1'b1; m_cnt = 0; end
         else m_cnt++;
      end else begin
         if (!mm) m_cnt = 0;
         else begin
            err = 1'b1;
            if (m_cnt == TH - 1) begin m_sync = 1'b0; m_cnt = 0; end
            else m_cnt++;
         end
      end
      m_sel_prev = sel;
      exp_q.push_back({err, !m_sync});
   endtask

   // Called at a falling edge: score the outputs, then drive the next word.
   task automatic cycle(input logic [W-1:0] w, input logic [3:0] sel);
      logic [1:0] e;
      call_n++;
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         check_eq("pn_err", int'(pn_err), int'(e[1]));
         check_eq("pn_oos", int'(pn_oos), int'(e[0]));
      end
      err_seen += int'(pn_err);
      if (pn_oos) seen_oos = 1'b1;
      else if (seen_oos && lock_call < 0) lock_call = call_n;
      data       = w;
      pn_seq_sel = sel;
      model_word(w, sel);
      @(negedge link_clk);
   endtask

   task automatic run_pn(input logic [3:0] sel, input int n);
      logic [W-1:0] w;
      for (int i = 0; i < n; i++) begin
         gen_word(sel, w);
         cycle(w, sel);
      end
   endtask

   task automatic mark();
      call_n    = 0;
      lock_call = -1;
      err_seen  = 0;
      seen_oos  = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      adc_rst = 1'b1;
      #1;
      check_eq({tag, "_oos"}, int'(pn_oos), 1);
      check_eq({tag, "_err"}, int'(pn_err), 0);
      @(negedge link_clk);
      @(negedge link_clk);
      check_eq({tag, "_held_oos"}, int'(pn_oos), 1);
      adc_rst    = 1'b0;
      exp_q.delete();
      m_hist     = '0;
      m_sync     = 1'b0;
      m_cnt      = 0;
      m_sel_prev = 4'h0;
   endtask

   initial begin
      logic [W-1:0] w;
      adc_rst    = 1'b1;
      data       = '0;
      pn_seq_sel = 4'h0;
      g_hist     = 31'h1;
      @(negedge link_clk);
      do_reset("rst0");

      // PN9 from reset: first word fails on zero history, 16 matches lock
      mark();
      run_pn(4'h0, 30);
      check_eq("t1_lock_call", lock_call, 20);
      check_eq("t1_err_seen", err_seen, 0);

      // PN23 lock, then a single flipped bit feeding the next word too
      run_pn(4'h1, 25);
      mark();
      gen_word(4'h1, w);
      w[5] = ~w[5];
      cycle(w, 4'h1);
      run_pn(4'h1, 10);
      check_eq("t2_err_seen", err_seen, 2);

      // 16 all-zero words while in sync
      mark();
      for (int i = 0; i < 16; i++) cycle('0, 4'h1);
      run_pn(4'h1, 6);
      check_eq("t3_err_seen", err_seen, 16);
      run_pn(4'h1, 20);

      // lock on PN9, then switch to PN15
      run_pn(4'h0, 25);
      check_eq("t4_pre_lock", int'(pn_oos), 0);
      mark();
      run_pn(4'h2, 22);
      check_eq("t4_lock_call", lock_call, 20);
      check_eq("t4_err_seen", err_seen, 0);

      // idle select, then PN31
      run_pn(4'h7, 10);
      if (g_hist == '0) g_hist = 31'h1;
      mark();
      run_pn(4'h3, 22);
      check_eq("t5_lock_call", lock_call, 20);
      check_eq("t5_err_seen", err_seen, 0);

      // asynchronous reset mid-word while in sync
      check_eq("t6_pre_lock", int'(pn_oos), 0);
      do_reset("t6_rst");
      mark();
      run_pn(4'h0, 25);
      check_eq("t6_lock_window", int'(lock_call >= 19 && lock_call <= 20), 1);
      check_eq("t6_err_seen", err_seen, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
